// File: rtl/hs32_mpu_pkg.sv
// Shared types and helpers for the hs32 MPU controller: FSM states,
// alignment-mask construction and region entry field extraction.
package hs32_mpu_pkg;

    typedef enum logic [1:0] {IDLE, SCAN, RESP} state_t;

    // Low `a` address bits are always don't-care, so force them into the mask.
    function automatic logic [31:0] algn_mask(input logic [31:0] mask, input int a);
        return mask | ((32'd1 << a) - 32'd1);
    endfunction

    function automatic logic [31:0] entry_base(input logic [31:0] entry, input int a);
        return entry & ~((32'd1 << a) - 32'd1);
    endfunction

    function automatic logic [31:0] entry_tag(input logic [31:0] entry, input int a);
        return entry & ((32'd1 << a) - 32'd1);
    endfunction

endpackage

// File: rtl/hs32_mpu_cmp.sv
// Single-entry region matcher: base compare under the aligned mask plus
// exact tag compare. Purely combinational; the controller time-shares one.
module hs32_mpu_cmp
    import hs32_mpu_pkg::*;
#(
    parameter int A = 3
) (
    input  logic [31:0]  entry,
    input  logic [31:0]  maskalgn,
    input  logic [31:0]  addr,
    input  logic [A-1:0] tag,
    output logic         hit
);

    logic w_base_hit;
    logic w_tag_hit;

    assign w_base_hit = ((entry_base(entry, A) ^ addr) & ~maskalgn) == 32'd0;
    assign w_tag_hit  = entry_tag(entry, A) == 32'(tag);
    assign hit        = w_base_hit && w_tag_hit;

endmodule

// File: rtl/hs32_mpu_ctl.sv
// MPU region table, mask and lock ownership, plus a sequential permission
// checker that scans one region per cycle through a shared comparator.
module hs32_mpu_ctl
    import hs32_mpu_pkg::*;
#(
    parameter  int NUM_REGNS = 8,
    localparam int ADDR_ALGN = $clog2(NUM_REGNS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cfg_we,
    input  logic                 cfg_sel,
    input  logic [ADDR_ALGN-1:0] cfg_idx,
    input  logic [31:0]          cfg_data,
    input  logic                 cfg_lock,
    output logic                 cfg_ready,
    input  logic                 chk_valid,
    output logic                 chk_ready,
    input  logic [31:0]          chk_addr,
    input  logic [ADDR_ALGN-1:0] chk_tag,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_ok,
    output logic [ADDR_ALGN-1:0] rsp_idx,
    output logic                 fault_o,
    output logic [31:0]          fault_addr,
    input  logic                 fault_clr
);

    state_t                 r_state, w_next;
    logic [31:0]            r_regn [NUM_REGNS];
    logic [31:0]            r_mask;
    logic                   r_lock;
    logic [31:0]            r_addr;
    logic [ADDR_ALGN-1:0]   r_tag;
    logic [ADDR_ALGN-1:0]   r_idx;
    logic                   r_rsp_ok;
    logic [ADDR_ALGN-1:0]   r_rsp_idx;
    logic                   r_fault;
    logic [31:0]            r_fault_addr;
    logic                   w_hit;
    logic                   w_last;
    logic [31:0]            w_maskalgn;

    assign w_maskalgn = algn_mask(r_mask, ADDR_ALGN);
    assign w_last     = r_idx == ADDR_ALGN'(NUM_REGNS - 1);

    hs32_mpu_cmp #(.A(ADDR_ALGN)) u_cmp (
        .entry    (r_regn[r_idx]),
        .maskalgn (w_maskalgn),
        .addr     (r_addr),
        .tag      (r_tag),
        .hit      (w_hit)
    );

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        cfg_ready = 1'b0;
        chk_ready = 1'b0;
        rsp_valid = 1'b0;
        unique case (r_state)
            IDLE: begin
                // A pending config write steals the cycle from the checker.
                cfg_ready = cfg_we & ~r_lock;
                chk_ready = ~cfg_we;
                if (chk_valid && !cfg_we) w_next = SCAN;
            end
            SCAN: if (w_hit || w_last) w_next = RESP;
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
        if (reset) begin
            cfg_ready = 1'b0;
            chk_ready = 1'b0;
            rsp_valid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGNS; i++) r_regn[i] <= '0;
            r_mask       <= '0;
            r_lock       <= 1'b0;
            r_addr       <= '0;
            r_tag        <= '0;
            r_idx        <= '0;
            r_rsp_ok     <= 1'b0;
            r_rsp_idx    <= '0;
            r_fault      <= 1'b0;
            r_fault_addr <= '0;
        end else begin
            if (cfg_lock) r_lock <= 1'b1;
            if (cfg_ready) begin
                if (cfg_sel) r_mask          <= cfg_data;
                else         r_regn[cfg_idx] <= cfg_data;
            end
            if (chk_valid && chk_ready) begin
                r_addr <= chk_addr;
                r_tag  <= chk_tag;
                r_idx  <= '0;
            end
            if (r_state == SCAN) begin
                if (w_hit) begin
                    r_rsp_ok  <= 1'b1;
                    r_rsp_idx <= r_idx;
                end else if (w_last) begin
                    r_rsp_ok  <= 1'b0;
                    r_rsp_idx <= '0;
                end else begin
                    r_idx <= r_idx + ADDR_ALGN'(1);
                end
            end
            // Clear wins over a same-cycle fault; only the first fault is kept.
            if (fault_clr) begin
                r_fault <= 1'b0;
            end else if (r_state == SCAN && !w_hit && w_last && !r_fault) begin
                r_fault      <= 1'b1;
                r_fault_addr <= r_addr;
            end
        end
    end

    assign rsp_ok     = r_rsp_ok;
    assign rsp_idx    = r_rsp_idx;
    assign fault_o    = r_fault;
    assign fault_addr = r_fault_addr;

endmodule

// File: doc/hs32_mpu_ctl.md
Name: hs32_mpu_ctl

Overview:
Owns the MPU region table and mask register, and sequences permission checks against them. Requesters submit (address, tag) checks over a valid/ready handshake. One shared comparator scans the regions one per cycle, which saves NUM_REGNS-1 comparators at the cost of latency. The block sits between the hs32 core's load/store path and the bus fabric, with a config write port driven by privileged CSR logic.

Parameters:
- NUM_REGNS, 8: number of region table entries; must be a power of 2, ≥2.
- ADDR_ALGN, $clog2(NUM_REGNS): derived localparam; tag width, and low address bits always treated as don't-care.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cfg_we  in  1  config write strobe.
- cfg_sel  in  1  0 = region entry, 1 = mask register.
- cfg_idx  in  ADDR_ALGN  region index for cfg_sel=0.
- cfg_data  in  32  write data. Region entry format is {base[31:A], tag[A-1:0]}.
- cfg_lock  in  1  sets the sticky lock bit.
- cfg_ready  out  1  write accepted this cycle.
- chk_valid  in  1  check request valid.
- chk_ready  out  1  check request accepted.
- chk_addr  in  32  address to check.
- chk_tag  in  ADDR_ALGN  requester tag.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumed.
- rsp_ok  out  1  1 = some region matched.
- rsp_idx  out  ADDR_ALGN  index of the matching region; 0 on miss.
- fault_o  out  1  sticky fault flag.
- fault_addr  out  32  address of the first faulting check.
- fault_clr  in  1  clears fault_o.

Behaviour:
- Reset: state=IDLE; regions=0; mask=0; lock=0; fault_o=0; fault_addr=0; rsp_valid=0; rsp_ok=0; rsp_idx=0; chk_ready=0; cfg_ready=0.
- Effective mask: maskalgn = mask | low ADDR_ALGN ones.
- Region i matches when both hold:
  - ((entry[31:A] ^ addr[31:A]) & ~maskalgn[31:A]) == 0.
  - entry[A-1:0] == tag.
- FSM has three states: IDLE, SCAN, RESP.
- IDLE:
  - cfg_ready=1 when cfg_we=1 and lock=0.
  - Config has priority: if cfg_we=1, chk_ready=0 that cycle.
  - Otherwise chk_ready=1. On chk_valid&chk_ready, latch addr/tag, set idx=0, go to SCAN.
- SCAN:
  - Compare region[idx] each cycle. Config writes stall (cfg_ready=0).
  - On match: rsp_ok=1, rsp_idx=idx, go to RESP.
  - On idx==NUM_REGNS-1 with no match: rsp_ok=0, rsp_idx=0, go to RESP. If fault_o==0, set fault_o=1 and fault_addr=latched addr.
  - Otherwise idx increments; it never wraps.
- RESP:
  - rsp_valid=1; rsp_ok/rsp_idx held stable until rsp_ready.
  - On rsp_ready, go to IDLE. No back-to-back accept: chk_ready=0 in RESP.
- Latency: a region-k match raises rsp_valid at cycle k+2 after the accept edge; a miss does so at cycle NUM_REGNS+1.
- Locking and config writes:
  - cfg_lock sets lock at any time, in any state; only reset clears it.
  - Writes while locked are dropped and cfg_ready=0.
  - A write takes effect the cycle after acceptance.
- Faults:
  - fault_clr has priority over a fault set in the same cycle. The fault is lost and fault_addr is unchanged.
  - Only the first fault is captured until cleared.
- Reset mid-SCAN or mid-RESP aborts the check; no response is produced.
- chk_addr and chk_tag are sampled only at accept; later changes are ignored.

Decomposition:
- Package hs32_mpu_pkg:
  - state enum {IDLE, SCAN, RESP}.
  - Function algn_mask(mask, A).
  - Region entry field-extract helpers.
- Sub-module hs32_mpu_cmp: purely combinational single-entry matcher.
  - Inputs: entry, maskalgn, addr, tag.
  - Output: hit.

Test Plan:
(NUM_REGNS=8, A=3 throughout.)
1. Match at index 5:
   - Setup: mask=0x3FFF_FFFF; region[5]=0x4000_0002.
   - Stimulus: check addr=0x7FFF_0000, tag=2.
   - Required: rsp_valid 7 cycles after accept, rsp_ok=1, rsp_idx=5; fault_o stays 0.
2. Miss and fault capture:
   - Stimulus: same table, addr=0x8000_0000, tag=2.
   - Required: rsp_valid 9 cycles after accept, rsp_ok=0; fault_o=1, fault_addr=0x8000_0000.
   - Then a second miss at 0x9000_0000: fault_addr stays 0x8000_0000.
3. Tag mismatch:
   - Stimulus: addr=0x4000_0000, tag=3 against region[5] tag 2, no other entries.
   - Required: rsp_ok=0.
   - Then pulse fault_clr together with a new miss completing: fault_o=0.
4. Lock:
   - Stimulus: assert cfg_lock, then write region[0]=0xFFFF_FFF8.
   - Required: cfg_ready=0 and readback via check unchanged; reset clears lock and zeroes regions.
5. Contention:
   - Stimulus: cfg_we and chk_valid high in the same IDLE cycle.
   - Required: the write is accepted first and chk_ready=0. The check is accepted the next cycle and sees the new entry.
   - cfg_we asserted during SCAN gets cfg_ready=0 until IDLE.
6. Back-pressure and reset:
   - Stimulus: hold rsp_ready=0 for 10 cycles.
   - Required: rsp_valid/rsp_ok stable and chk_ready=0.
   - Reset asserted mid-SCAN: next cycle rsp_valid=0 and state is IDLE.
